router_oport_arbiter: RTL

Per-output-port arbiter for the 4x4 router. It collects the o_req / o_dst_addr pair from every router input port and grants each output port to one input at a time, using round-robin priority per output. It holds each grant for the whole frame and releases it when the owning input's frame ends. The grant vector drives i_gnt of the input ports; the select vector drives the crossbar mux.

---
 rtl/router_oport_arbiter.sv | 79 +++++++
 1 files changed

// File: rtl/router_oport_arbiter.sv
// Per-output round-robin arbiter for the 4x4 router: grants each output to one
// input for the duration of its frame and drives the crossbar select.
module router_oport_arbiter #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned ADDR_W    = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_PORTS-1:0]          i_req,
    input  logic [NUM_PORTS-1:0]          i_frame,
    input  logic [NUM_PORTS*ADDR_W-1:0]   i_dst_addr,
    output logic [NUM_PORTS-1:0]          o_gnt,
    output logic [NUM_PORTS-1:0]          o_out_busy,
    output logic [NUM_PORTS*ADDR_W-1:0]   o_out_sel
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            state [NUM_PORTS];
    logic [ADDR_W-1:0] ptr   [NUM_PORTS];
    logic [ADDR_W-1:0] win   [NUM_PORTS];
    logic              found [NUM_PORTS];

    // Round-robin search per output, starting at ptr[o] and wrapping at ADDR_W bits.
    always_comb begin
        for (int unsigned o = 0; o < NUM_PORTS; o++) begin
            found[o] = 1'b0;
            win[o]   = '0;
            for (int unsigned k = 0; k < NUM_PORTS; k++) begin
                logic [ADDR_W-1:0] idx;
                idx = ptr[o] + ADDR_W'(k);
                if (!found[o] && i_req[idx] && !o_gnt[idx] &&
                    (i_dst_addr[idx*ADDR_W +: ADDR_W] == ADDR_W'(o))) begin
                    found[o] = 1'b1;
                    win[o]   = idx;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            o_gnt      <= '0;
            o_out_busy <= '0;
            o_out_sel  <= '0;
            for (int unsigned o = 0; o < NUM_PORTS; o++) begin
                ptr[o]   <= '0;
                state[o] <= IDLE;
            end
        end else begin
            // Each input targets one output, so the grant bits touched here never collide.
            for (int unsigned o = 0; o < NUM_PORTS; o++) begin
                case (state[o])
                    IDLE: begin
                        if (found[o]) begin
                            o_gnt[win[o]]                  <= 1'b1;
                            o_out_sel[o*ADDR_W +: ADDR_W]  <= win[o];
                            o_out_busy[o]                  <= 1'b1;
                            ptr[o]                         <= win[o] + 1'b1;
                            state[o]                       <= BUSY;
                        end
                    end
                    BUSY: begin
                        if (!i_frame[o_out_sel[o*ADDR_W +: ADDR_W]]) begin
                            o_gnt[o_out_sel[o*ADDR_W +: ADDR_W]] <= 1'b0;
                            o_out_busy[o]                        <= 1'b0;
                            state[o]                             <= IDLE;
                        end
                    end
                    default: state[o] <= IDLE;
                endcase
            end
        end
    end

endmodule
